load_unit: RTL and testbench
============================

Name: load_unit

Overview:
- Execution stage directly downstream of the load reservation station.
- Accepts one address-resolved load per issue: effective address, load subtype, destination ROB tag.
- Performs a word read on the data-memory port, then extracts and sign- or zero-extends the addressed byte, half or word.
- Broadcasts the result on its CDB port through a request/grant handshake; `busy` back-pressures the reservation station.

Parameters:
- ADDR_W, 32, effective/memory address width.
- ROB_W, 6, ROB tag width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash of any in-flight load.
- issue_valid  input  1  load presented by the reservation station this cycle.
- issue_addr  input  ADDR_W  effective address (base + offset).
- issue_type  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- issue_rob  input  ROB_W  destination ROB tag.
- busy  output  1  high whenever state != IDLE.
- mem_req  output  1  data-memory read request.
- mem_addr  output  ADDR_W  {addr[ADDR_W-1:2],2'b00}.
- mem_ready  input  1  read data valid; sampled only while mem_req=1.
- mem_rdata  input  32  little-endian read word.
- cdb_req  output  1  CDB broadcast request.
- cdb_grant  input  1  CDB arbiter grant.
- cdb_data  output  32  extended load result.
- cdb_rob  output  ROB_W  tag of broadcast result.
- cdb_exc  output  1  misaligned-load exception flag (see Optional Feature).

Behaviour:
- Reset: asynchronous, active-high; clock is `clock`. Asserting reset forces state=IDLE and busy=0. It also clears mem_req, cdb_req and cdb_exc, and zeroes mem_addr, cdb_data, cdb_rob and all internal latches. Reset mid-operation abandons the load.
- FSM, all transitions on the rising edge:
  - IDLE -> REQ when issue_valid=1. On that edge, latch addr, type and rob. issue_valid is ignored in every other state.
  - REQ: mem_req=1 and mem_addr=aligned latched address. On an edge with mem_ready=1, capture the extracted result into cdb_data and go to BCAST. mem_req is held until then; there is no timeout.
  - BCAST: cdb_req=1, with cdb_data and cdb_rob stable. On an edge with cdb_grant=1 go to IDLE. cdb_req and busy drop in the following cycle.
- Latency: issue at edge N; mem_req high in cycle N+1. With mem_ready at edge N+1, cdb_req is high in N+2. With grant at N+2, busy=0 in N+3 and a new issue is accepted at edge N+3. Minimum throughput is 1 load per 3 cycles.
- Extraction, with off = addr[1:0]:
  - LB/LBU: byte mem_rdata[8*off+7 : 8*off].
  - LH/LHU: half mem_rdata[16*addr[1]+15 : 16*addr[1]].
  - LW: full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Undefined types 011/110/111 return 0 with cdb_exc=0.
- flush=1 at an edge in any state: go to IDLE and clear mem_req and cdb_req next cycle. flush beats a simultaneous issue_valid, mem_ready or cdb_grant, and the result is never broadcast. A mem_ready that arrives late after a flush is ignored because mem_req=0.
- Precedence at an edge is reset > flush > normal transitions.

Optional Feature:
- Macro MISALIGN_CHECK_EN.
- Defined: in IDLE on issue, LH/LHU with addr[0]=1 or LW with addr[1:0]!=0 skips REQ and goes straight to BCAST. It broadcasts cdb_data=0, cdb_exc=1, with no mem_req. cdb_exc clears when the grant is taken.
- Not defined: cdb_exc is tied to 0. Misaligned loads read the aligned word and extract using addr[1] (halves) or the whole word (LW).

Test Plan:
- Reset/idle: assert reset asynchronously mid-REQ -> busy, mem_req, cdb_req and cdb_exc go to 0 immediately; after release, state is IDLE.
- LB sign: issue addr=0x103, type=000, rob=5; mem_rdata=0x80AABBCC, mem_ready one cycle after mem_req -> mem_addr=0x100, cdb_data=0xFFFFFF80, cdb_rob=5. Grant in the first BCAST cycle -> busy low 3 cycles after issue.
- LHU/LW: addr=0x202 type=101 with rdata=0x8001_1234 -> 0x00008001; addr=0x200 type=010 -> 0x80011234.
- Stalls: mem_ready withheld 4 cycles, then cdb_grant withheld 3 cycles -> mem_req and cdb_req held constant with stable outputs. An issue_valid pulse during busy is ignored.
- Flush: flush in REQ with mem_ready arriving the same edge, and again in BCAST with grant the same edge -> no broadcast; IDLE the next cycle; the next issue is accepted normally.
- MISALIGN_CHECK_EN: LW at 0x301 -> no mem_req, cdb_req in cycle N+1 with cdb_exc=1 and cdb_data=0. With the macro undefined -> mem_addr=0x300, cdb_exc=0.

Source files
------------

// File: rtl/load_unit.sv
// load_unit: single-entry load stage (aligned word read, byte/half/word extend, CDB broadcast).
// Optional MISALIGN_CHECK_EN: misaligned LH/LHU/LW raise cdb_exc instead of reading memory.
module load_unit #(
  parameter int ADDR_W = 32,
  parameter int ROB_W  = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [2:0]        issue_type,
  input  logic [ROB_W-1:0]  issue_rob,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic [31:0]       cdb_data,
  output logic [ROB_W-1:0]  cdb_rob,
  output logic              cdb_exc
);

  typedef enum logic [1:0] {IDLE, REQ, BCAST} state_t;

  state_t     state;
  logic [1:0] lat_off;
  logic [2:0] lat_type;
  logic       misaligned;

  function automatic logic [31:0] extract(input logic [31:0] word,
                                          input logic [1:0]  off,
                                          input logic [2:0]  ltype);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v = word[{off, 3'b000} +: 8];
    half_v = off[1] ? word[31:16] : word[15:0];
    case (ltype)
      3'b000:  extract = {{24{byte_v[7]}}, byte_v};
      3'b001:  extract = {{16{half_v[15]}}, half_v};
      3'b010:  extract = word;
      3'b100:  extract = {24'd0, byte_v};
      3'b101:  extract = {16'd0, half_v};
      default: extract = 32'd0;
    endcase
  endfunction

`ifdef MISALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    case (issue_type)
      3'b001, 3'b101: misaligned = issue_addr[0];
      3'b010:         misaligned = |issue_addr[1:0];
      default:        misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
  assign cdb_exc    = 1'b0;
`endif

  // mem_req is high exactly while in REQ, so mem_ready is only honoured there.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      cdb_req  <= 1'b0;
      cdb_data <= '0;
      cdb_rob  <= '0;
      lat_off  <= '0;
      lat_type <= '0;
`ifdef MISALIGN_CHECK_EN
      cdb_exc  <= 1'b0;
`endif
    end else if (flush) begin
      state   <= IDLE;
      busy    <= 1'b0;
      mem_req <= 1'b0;
      cdb_req <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      cdb_exc <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (issue_valid) begin
            busy     <= 1'b1;
            lat_off  <= issue_addr[1:0];
            lat_type <= issue_type;
            cdb_rob  <= issue_rob;
            mem_addr <= {issue_addr[ADDR_W-1:2], 2'b00};
            if (misaligned) begin
              state    <= BCAST;
              cdb_req  <= 1'b1;
              cdb_data <= '0;
`ifdef MISALIGN_CHECK_EN
              cdb_exc  <= 1'b1;
`endif
            end else begin
              state   <= REQ;
              mem_req <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            cdb_data <= extract(mem_rdata, lat_off, lat_type);
            mem_req  <= 1'b0;
            cdb_req  <= 1'b1;
            state    <= BCAST;
          end
        end
        BCAST: begin
          if (cdb_grant) begin
            state   <= IDLE;
            cdb_req <= 1'b0;
            busy    <= 1'b0;
`ifdef MISALIGN_CHECK_EN
            cdb_exc <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: table-driven load vectors with a result scoreboard, plus reset/flush sequences.
module tb_load_unit;

  localparam int ADDR_W = 32;
  localparam int ROB_W  = 6;

  logic              clock = 1'b0;
  logic              reset, flush, issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic [2:0]        issue_type;
  logic [ROB_W-1:0]  issue_rob;
  logic              busy, mem_req, mem_ready, cdb_req, cdb_grant, cdb_exc;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata, cdb_data;
  logic [ROB_W-1:0]  cdb_rob;

  load_unit #(.ADDR_W(ADDR_W), .ROB_W(ROB_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_type(issue_type),
    .issue_rob(issue_rob), .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .cdb_req(cdb_req),
    .cdb_grant(cdb_grant), .cdb_data(cdb_data), .cdb_rob(cdb_rob), .cdb_exc(cdb_exc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  ltype;
    logic [5:0]  rob;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic [31:0] exp_maddr;
    logic        exp_exc;
    int          mem_delay;
    int          grant_delay;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  rob;
    logic        exc;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Runs one full load; during stalls a stray issue pulse must be ignored.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   waited;
    @(negedge clock);
    issue_valid = 1'b1; issue_addr = v.addr; issue_type = v.ltype; issue_rob = v.rob;
    @(negedge clock);
    issue_valid = 1'b0;
    sb.push_back('{v.exp_data, v.rob, v.exp_exc});
    checkOutput("busy_after_issue", 32'(busy), 32'd1);
    if (!v.exp_exc) begin
      checkOutput("mem_req", 32'(mem_req), 32'd1);
      checkOutput("mem_addr", mem_addr, v.exp_maddr);
      for (int i = 0; i < v.mem_delay; i++) begin
        issue_valid = 1'b1; issue_addr = 32'hFFF0; issue_type = 3'b010; issue_rob = 6'd63;
        @(negedge clock);
        issue_valid = 1'b0;
        checkOutput("mem_req_hold", 32'(mem_req), 32'd1);
        checkOutput("mem_addr_hold", mem_addr, v.exp_maddr);
        checkOutput("cdb_req_during_stall", 32'(cdb_req), 32'd0);
      end
      mem_ready = 1'b1; mem_rdata = v.rdata;
      @(negedge clock);
      mem_ready = 1'b0; mem_rdata = $urandom;
    end else begin
      checkOutput("mem_req_skipped", 32'(mem_req), 32'd0);
    end
    waited = 0;
    while (!cdb_req && waited < 8) begin
      @(negedge clock);
      waited++;
    end
    checkOutput("cdb_latency", 32'(waited), 32'd0);
    if (sb.size() == 0) begin
      checkOutput("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput("cdb_req", 32'(cdb_req), 32'd1);
      checkOutput("cdb_data", cdb_data, e.data);
      checkOutput("cdb_rob", 32'(cdb_rob), 32'(e.rob));
      checkOutput("cdb_exc", 32'(cdb_exc), 32'(e.exc));
    end
    for (int i = 0; i < v.grant_delay; i++) begin
      issue_valid = 1'b1; issue_addr = 32'hFFF0; issue_rob = 6'd62;
      @(negedge clock);
      issue_valid = 1'b0;
      checkOutput("cdb_req_hold", 32'(cdb_req), 32'd1);
      checkOutput("cdb_data_hold", cdb_data, v.exp_data);
      checkOutput("cdb_rob_hold", 32'(cdb_rob), 32'(v.rob));
    end
    cdb_grant = 1'b1;
    @(negedge clock);
    cdb_grant = 1'b0;
    checkOutput("busy_after_grant", 32'(busy), 32'd0);
    checkOutput("cdb_req_after_grant", 32'(cdb_req), 32'd0);
    checkOutput("cdb_exc_after_grant", 32'(cdb_exc), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h103, 3'b000, 6'd5,  32'h80AABBCC, 32'hFFFFFF80, 32'h100, 1'b0, 0, 0};
    vecs[1] = '{32'h202, 3'b101, 6'd7,  32'h80011234, 32'h00008001, 32'h200, 1'b0, 4, 3};
    vecs[2] = '{32'h200, 3'b010, 6'd9,  32'h80011234, 32'h80011234, 32'h200, 1'b0, 0, 0};
    vecs[3] = '{32'h101, 3'b100, 6'd3,  32'h80AABBCC, 32'h000000BB, 32'h100, 1'b0, 1, 0};
    vecs[4] = '{32'h100, 3'b001, 6'd12, 32'h1234F00D, 32'hFFFFF00D, 32'h100, 1'b0, 0, 1};
    vecs[5] = '{32'h102, 3'b000, 6'd1,  32'h00557F00, 32'h00000055, 32'h100, 1'b0, 0, 0};
    vecs[6] = '{32'h104, 3'b011, 6'd2,  32'hFFFFFFFF, 32'h00000000, 32'h104, 1'b0, 0, 0};
`ifdef MISALIGN_CHECK_EN
    vecs[7] = '{32'h301, 3'b010, 6'd33, 32'hDEADBEEF, 32'h00000000, 32'h300, 1'b1, 0, 0};
    vecs[8] = '{32'h203, 3'b101, 6'd40, 32'hCAFE0001, 32'h00000000, 32'h200, 1'b1, 0, 2};
`else
    vecs[7] = '{32'h301, 3'b010, 6'd33, 32'hDEADBEEF, 32'hDEADBEEF, 32'h300, 1'b0, 0, 0};
    vecs[8] = '{32'h203, 3'b101, 6'd40, 32'hCAFE0001, 32'h0000CAFE, 32'h200, 1'b0, 0, 2};
`endif

    reset = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_addr = '0; issue_type = '0;
    issue_rob = '0; mem_ready = 1'b0; mem_rdata = '0; cdb_grant = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset_cdb_req", 32'(cdb_req), 32'd0);
    checkOutput("reset_cdb_exc", 32'(cdb_exc), 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);
    checkOutput("reset_cdb_data", cdb_data, 32'd0);
    checkOutput("reset_cdb_rob", 32'(cdb_rob), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Asynchronous reset in the middle of REQ.
    @(negedge clock);
    issue_valid = 1'b1; issue_addr = 32'h500; issue_type = 3'b010; issue_rob = 6'd21;
    @(negedge clock);
    issue_valid = 1'b0;
    checkOutput("pre_reset_mem_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_busy", 32'(busy), 32'd0);
    checkOutput("async_reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("async_reset_cdb_req", 32'(cdb_req), 32'd0);
    checkOutput("async_reset_cdb_exc", 32'(cdb_exc), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);
    checkOutput("post_reset_mem_addr", mem_addr, 32'd0);

    // Flush in REQ racing mem_ready, then a late mem_ready.
    issue_valid = 1'b1; issue_addr = 32'h400; issue_type = 3'b010; issue_rob = 6'd20;
    @(negedge clock);
    issue_valid = 1'b0;
    checkOutput("flush_req_mem_req", 32'(mem_req), 32'd1);
    flush = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h11223344;
    @(negedge clock);
    flush = 1'b0;
    checkOutput("flush_req_mem_req_low", 32'(mem_req), 32'd0);
    checkOutput("flush_req_busy", 32'(busy), 32'd0);
    checkOutput("flush_req_cdb_req", 32'(cdb_req), 32'd0);
    @(negedge clock);
    mem_ready = 1'b0;
    checkOutput("late_ready_cdb_req", 32'(cdb_req), 32'd0);
    checkOutput("late_ready_busy", 32'(busy), 32'd0);

    // Flush in BCAST racing cdb_grant.
    issue_valid = 1'b1; issue_addr = 32'h404; issue_type = 3'b100; issue_rob = 6'd22;
    @(negedge clock);
    issue_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h000000AA;
    @(negedge clock);
    mem_ready = 1'b0;
    checkOutput("flush_bcast_cdb_req", 32'(cdb_req), 32'd1);
    flush = 1'b1; cdb_grant = 1'b1;
    @(negedge clock);
    flush = 1'b0; cdb_grant = 1'b0;
    checkOutput("flush_bcast_cdb_req_low", 32'(cdb_req), 32'd0);
    checkOutput("flush_bcast_busy", 32'(busy), 32'd0);
    @(negedge clock);
    checkOutput("flush_bcast_stays_idle", 32'(cdb_req), 32'd0);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    applyStimulus(vecs[0]);
    applyStimulus(vecs[2]);

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
